// File: rtl/dynode_pkg.sv
// Shared widths, field layout and event word type for the dynode event path.
// The packed struct order matches the readout word: ingcnt on top, time at the bottom.
package dynode_pkg;

   localparam int ENERGY_W   = 12;
   localparam int INGCNT_W   = 4;
   localparam int TIME_W     = 24;
   localparam int EV_W       = INGCNT_W + ENERGY_W + TIME_W;

   localparam int TIME_LSB   = 0;
   localparam int ENERGY_LSB = TIME_LSB + TIME_W;
   localparam int INGCNT_LSB = ENERGY_LSB + ENERGY_W;

   typedef struct packed {
      logic [INGCNT_W-1:0] ingcnt;
      logic [ENERGY_W-1:0] energy;
      logic [TIME_W-1:0]   evntim;
   } event_t;

   // Inclusive unsigned window; an inverted window (lo > hi) matches nothing.
   function automatic logic in_window(input logic [ENERGY_W-1:0] energy,
                                      input logic [ENERGY_W-1:0] lo,
                                      input logic [ENERGY_W-1:0] hi);
      return (energy >= lo) && (energy <= hi);
   endfunction

endpackage

// File: rtl/dynode_event_buffer_if.sv
// Readout stream between the event buffer and its downstream consumer.
interface dynode_event_buffer_if #(
   parameter int W = dynode_pkg::EV_W
);
   logic         ev_valid;
   logic         ev_ready;
   logic [W-1:0] ev_data;

   modport master (output ev_valid, output ev_data, input ev_ready);
   modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/dynode_evfifo.sv
// Circular event store with synchronous write; the head word is captured by the
// consumer's output register, so reads take effect on the clock edge.
module dynode_evfifo #(
   parameter int DEPTH = 16,
   parameter int CAP   = DEPTH,
   parameter int W     = 40
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign full    = (count == CW'(CAP));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dynode_event_buffer.sv
// Energy-windowed event buffer: one register stage, window qualification, FIFO
// storage and a first-word-fall-through output register with statistics.
module dynode_event_buffer
   import dynode_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNTW  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ene_load,
   input  logic [ENERGY_W-1:0]    dyn_energy,
   input  logic [INGCNT_W-1:0]    dyn_ingcnt,
   input  logic [TIME_W-1:0]      dyn_evntim,
   input  logic                   win_en,
   input  logic [ENERGY_W-1:0]    e_lo,
   input  logic [ENERGY_W-1:0]    e_hi,
   input  logic                   clr_stats,
   dynode_event_buffer_if.master  ev,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   ovf_flag,
   output logic [CNTW-1:0]        cnt_accept,
   output logic [CNTW-1:0]        cnt_reject,
   output logic [CNTW-1:0]        cnt_ovf
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic            s1_valid;
   event_t          s1_event;
   logic            s1_qual;
   logic            out_valid;
   event_t          out_event;
   logic            pop;
   logic            take_slot;
   logic            wr_ok;
   logic            bypass;
   logic            mem_wr;
   logic            mem_rd;
   logic            mem_full;
   logic            mem_empty;
   logic [EV_W-1:0] mem_head;
   logic [CW-1:0]   mem_count;
   logic            rej_evt;
   logic            ovf_evt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_event <= '0;
      end else begin
         s1_valid <= ene_load;
         s1_event <= {dyn_ingcnt, dyn_energy, dyn_evntim};
      end
   end

   assign s1_qual   = !win_en || in_window(s1_event.energy, e_lo, e_hi);
   assign pop       = out_valid && ev.ev_ready;
   assign take_slot = !out_valid || pop;

   // The memory holds DEPTH-1 words because the output register is the last slot,
   // so a full memory always means the whole buffer is full.
   assign wr_ok   = s1_valid && s1_qual && (!mem_full || pop);
   assign mem_rd  = take_slot && !mem_empty;
   assign bypass  = wr_ok && take_slot && mem_empty;
   assign mem_wr  = wr_ok && !bypass;
   assign rej_evt = s1_valid && !s1_qual;
   assign ovf_evt = s1_valid && s1_qual && !wr_ok;

   dynode_evfifo #(
      .DEPTH (DEPTH),
      .CAP   (DEPTH - 1),
      .W     (EV_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (mem_wr),
      .wr_data (s1_event),
      .rd_en   (mem_rd),
      .rd_data (mem_head),
      .full    (mem_full),
      .empty   (mem_empty),
      .count   (mem_count)
   );

   // An empty output slot is refilled from memory first, otherwise straight from stage 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_event <= '0;
      end else if (take_slot) begin
         if (!mem_empty) begin
            out_valid <= 1'b1;
            out_event <= mem_head;
         end else if (wr_ok) begin
            out_valid <= 1'b1;
            out_event <= s1_event;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_accept <= '0;
         cnt_reject <= '0;
         cnt_ovf    <= '0;
         ovf_flag   <= 1'b0;
      end else if (clr_stats) begin
         cnt_accept <= '0;
         cnt_reject <= '0;
         cnt_ovf    <= '0;
         ovf_flag   <= 1'b0;
      end else begin
         if (wr_ok && (cnt_accept != '1))   cnt_accept <= cnt_accept + CNTW'(1);
         if (rej_evt && (cnt_reject != '1)) cnt_reject <= cnt_reject + CNTW'(1);
         if (ovf_evt && (cnt_ovf != '1))    cnt_ovf    <= cnt_ovf + CNTW'(1);
         if (ovf_evt)                       ovf_flag   <= 1'b1;
      end
   end

   assign ev.ev_valid = out_valid;
   assign ev.ev_data  = out_event;
   assign fifo_count  = mem_count + CW'(out_valid);

endmodule

// File: tb/tb_dynode_event_buffer.sv
// Directed and randomized bench for dynode_event_buffer against a queue-based
// model of the buffer's accept/drop/readout rules.
module tb_dynode_event_buffer;
   import dynode_pkg::*;

   localparam int DEPTH = 16;
   localparam int CNTW  = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                ene_load = 1'b0;
   logic [ENERGY_W-1:0] dyn_energy = '0;
   logic [INGCNT_W-1:0] dyn_ingcnt = '0;
   logic [TIME_W-1:0]   dyn_evntim = '0;
   logic                win_en = 1'b0;
   logic [ENERGY_W-1:0] e_lo = '0;
   logic [ENERGY_W-1:0] e_hi = '0;
   logic                clr_stats = 1'b0;
   logic [CW-1:0]       fifo_count;
   logic                ovf_flag;
   logic [CNTW-1:0]     cnt_accept;
   logic [CNTW-1:0]     cnt_reject;
   logic [CNTW-1:0]     cnt_ovf;

   dynode_event_buffer_if ev_bus ();

   dynode_event_buffer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk        (clk),
      .reset      (reset),
      .ene_load   (ene_load),
      .dyn_energy (dyn_energy),
      .dyn_ingcnt (dyn_ingcnt),
      .dyn_evntim (dyn_evntim),
      .win_en     (win_en),
      .e_lo       (e_lo),
      .e_hi       (e_hi),
      .clr_stats  (clr_stats),
      .ev         (ev_bus),
      .fifo_count (fifo_count),
      .ovf_flag   (ovf_flag),
      .cnt_accept (cnt_accept),
      .cnt_reject (cnt_reject),
      .cnt_ovf    (cnt_ovf)
   );

   always #5 clk = ~clk;

   // Reference model: the queue holds every accepted, not yet popped word in order.
   logic [EV_W-1:0]     exp_q[$];
   bit                  pend_valid = 1'b0;
   logic [ENERGY_W-1:0] pend_energy = '0;
   logic [EV_W-1:0]     pend_word = '0;
   int                  m_acc = 0;
   int                  m_rej = 0;
   int                  m_ovf = 0;
   bit                  m_flag = 1'b0;
   int                  checks = 0;
   int                  errors = 0;
   int                  loaded;
   bit                  ld;

   function automatic int sat_inc(input int v);
      return (v == (1 << CNTW) - 1) ? v : v + 1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit ready);
      bit full;
      bit pop;
      full = (exp_q.size() == DEPTH);
      pop  = (exp_q.size() > 0) && ready;
      if (pop) exp_q.delete(0);
      if (pend_valid) begin
         if (!win_en || (pend_energy >= e_lo && pend_energy <= e_hi)) begin
            if (full && !pop) begin
               m_ovf  = sat_inc(m_ovf);
               m_flag = 1'b1;
            end else begin
               exp_q.push_back(pend_word);
               m_acc = sat_inc(m_acc);
            end
         end else begin
            m_rej = sat_inc(m_rej);
         end
      end
      if (clr_stats) begin
         m_acc  = 0;
         m_rej  = 0;
         m_ovf  = 0;
         m_flag = 1'b0;
      end
      pend_valid  = ene_load;
      pend_energy = dyn_energy;
      pend_word   = {dyn_ingcnt, dyn_energy, dyn_evntim};
   endtask

   task automatic model_reset();
      exp_q.delete();
      pend_valid = 1'b0;
      m_acc  = 0;
      m_rej  = 0;
      m_ovf  = 0;
      m_flag = 1'b0;
   endtask

   task automatic checkOutput();
      check("ev_valid", ev_bus.ev_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("ev_data", ev_bus.ev_data, exp_q[0]);
      check("fifo_count", fifo_count, exp_q.size());
      check("cnt_accept", cnt_accept, m_acc);
      check("cnt_reject", cnt_reject, m_rej);
      check("cnt_ovf", cnt_ovf, m_ovf);
      check("ovf_flag", ovf_flag, m_flag);
   endtask

   task automatic applyStimulus(input bit load, input logic [ENERGY_W-1:0] energy,
                                input logic [INGCNT_W-1:0] ingcnt,
                                input logic [TIME_W-1:0] evntim, input bit ready);
      ene_load        = load;
      dyn_energy      = energy;
      dyn_ingcnt      = ingcnt;
      dyn_evntim      = evntim;
      ev_bus.ev_ready = ready;
      @(posedge clk);
      model_edge(ready);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n, input bit ready);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, ready);
   endtask

   initial begin
      ev_bus.ev_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      reset = 1'b0;

      $display("[TB] single event");
      idle(3, 1'b1);
      applyStimulus(1'b1, 12'h123, 4'h4, 24'h00ABCD, 1'b1);
      check("single_early", ev_bus.ev_valid, 1'b0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      check("single_valid", ev_bus.ev_valid, 1'b1);
      check("single_data", ev_bus.ev_data, 40'h41230_0ABCD);
      check("single_acc", cnt_accept, 1);
      idle(3, 1'b1);

      $display("[TB] energy window");
      clr_stats = 1'b1;
      idle(1, 1'b1);
      clr_stats = 1'b0;
      win_en = 1'b1;
      e_lo   = 12'd100;
      e_hi   = 12'd200;
      applyStimulus(1'b1, 12'd99,  4'h1, 24'h000001, 1'b1);
      applyStimulus(1'b1, 12'd100, 4'h2, 24'h000002, 1'b1);
      applyStimulus(1'b1, 12'd200, 4'h3, 24'h000003, 1'b1);
      applyStimulus(1'b1, 12'd201, 4'h4, 24'h000004, 1'b1);
      idle(5, 1'b1);
      check("win_acc", cnt_accept, 2);
      check("win_rej", cnt_reject, 2);
      e_lo = 12'd200;
      e_hi = 12'd100;
      applyStimulus(1'b1, 12'd150, 4'h5, 24'h000005, 1'b1);
      idle(3, 1'b1);
      check("inverted_rej", cnt_reject, 3);
      win_en = 1'b0;

      $display("[TB] overflow");
      clr_stats = 1'b1;
      idle(1, 1'b0);
      clr_stats = 1'b0;
      for (int i = 0; i < 18; i++)
         applyStimulus(1'b1, 12'($urandom), 4'($urandom), 24'(i), 1'b0);
      idle(1, 1'b0);
      check("ovf_count", fifo_count, DEPTH);
      check("ovf_cnt", cnt_ovf, 2);
      check("ovf_flag_set", ovf_flag, 1'b1);

      $display("[TB] full with simultaneous pop");
      applyStimulus(1'b1, 12'hABC, 4'hA, 24'h777777, 1'b0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      check("fullpop_count", fifo_count, DEPTH);
      check("fullpop_ovf", cnt_ovf, 2);
      idle(DEPTH + 3, 1'b1);
      check("drained", fifo_count, 0);

      $display("[TB] random backpressure");
      win_en = 1'b1;
      e_lo   = 12'h100;
      e_hi   = 12'hE00;
      loaded = 0;
      while (loaded < 1000) begin
         ld = ($urandom_range(0, 9) < 7);
         applyStimulus(ld, 12'($urandom), 4'($urandom), 24'($urandom),
                       $urandom_range(0, 9) < 6);
         if (ld) loaded++;
      end
      idle(DEPTH + 4, 1'b1);
      win_en = 1'b0;

      $display("[TB] reset mid-run");
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 12'($urandom), 4'($urandom), 24'($urandom), 1'b0);
      idle(2, 1'b0);
      check("pre_reset_count", fifo_count, 5);
      #3;
      reset = 1'b1;
      #1;
      check("rst_valid", ev_bus.ev_valid, 1'b0);
      check("rst_count", fifo_count, 0);
      check("rst_acc", cnt_accept, 0);
      check("rst_ovf", cnt_ovf, 0);
      check("rst_flag", ovf_flag, 1'b0);
      model_reset();
      #2;
      reset = 1'b0;
      idle(5, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dynode_event_buffer.md
DYNODE_EVENT_BUFFER -- requirements
Module: dynode_event_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in events; power of two, 4..64.
REQ-002 Parameter CNTW, default 16, width of statistics counters.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ene_load  input  1  one-cycle strobe: energy result valid.
REQ-006 dyn_energy  input  12  baseline-corrected integrated energy.
REQ-007 dyn_ingcnt  input  4  integration sample count.
REQ-008 dyn_evntim  input  24  event start time.
REQ-009 win_en  input  1  1 = apply energy window; 0 = accept all.
REQ-010 e_lo, e_hi  input  12 each  inclusive energy window bounds.
REQ-011 clr_stats  input  1  synchronous clear of counters and overflow flag.
REQ-012 ev_ready  input  1  downstream readout accepts word.
REQ-013 ev_valid  output  1  ev_data holds a valid event.
REQ-014 ev_data  output  40  {dyn_ingcnt[39:36], dyn_energy[35:24], dyn_evntim[23:0]}.
REQ-015 fifo_count  output  log2(DEPTH)+1  events stored, including the output register.
REQ-016 ovf_flag  output  1  sticky: an event was dropped on full.
REQ-017 cnt_accept, cnt_reject, cnt_ovf  output  CNTW each  saturating counters.

Function
REQ-018 Stage 1 SHALL register ene_load and its inputs unchanged; no other input capture.
REQ-019 Stage 1 event qualifies when win_en=0, or e_lo <= energy <= e_hi (unsigned); e_lo > e_hi rejects all.
REQ-020 Qualified event SHALL be written to FIFO on the edge after stage 1; non-qualified increments cnt_reject.
REQ-021 Event write with FIFO full and no pop in the same cycle SHALL be dropped; set ovf_flag and increment cnt_ovf, not cnt_accept.
REQ-022 Write when full with a simultaneous pop SHALL be accepted (count unchanged).
REQ-023 Accepted writes increment cnt_accept; counters saturate at all-ones, never wrap.
REQ-024 Output is first-word-fall-through: into an empty buffer, ev_valid rises 2 cycles after the ene_load cycle (ene_load at N, ev_valid at N+2).
REQ-025 Pop SHALL occur when ev_valid and ev_ready are both 1 at a rising edge; the next word (if any) is presented the following cycle with no bubble.
REQ-026 ev_data SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-027 ev_valid SHALL never deassert without a pop.
REQ-028 Order SHALL be preserved; read/write pointers wrap modulo DEPTH.
REQ-029 clr_stats zeroes counters and ovf_flag next edge; it has priority over same-cycle increments; FIFO contents unaffected.
REQ-030 ene_load asserted on consecutive cycles SHALL be accepted every cycle (throughput 1 event/clk).

Reset
REQ-031 reset SHALL asynchronously clear pointers, fifo_count, stage-1 valid, ev_valid, ev_data, counters, and ovf_flag to 0.
REQ-032 Reset mid-operation discards all stored and in-flight events; no event is output after release until a new ene_load.
REQ-033 Memory array contents need not be reset.

Structure
REQ-034 Shared package dynode_pkg SHALL hold the 40-bit event word width, field offsets, and energy/time widths.
REQ-035 Storage SHALL be one sub-module, dynode_evfifo (synchronous-write, registered-read FIFO with full/empty/count); window check, counters, and FWFT output stay in the top level.

Verification
REQ-036 Single event: win_en=0, ene_load at cycle 10, energy=0x123, ingcnt=4, time=0x00ABCD, ready=1 -> ev_valid at cycle 12, ev_data=0x41230 0ABCD, cnt_accept=1.
REQ-037 Window: e_lo=100, e_hi=200, events of energy 99, 100, 200, 201 -> only 100 and 200 output, cnt_accept=2, cnt_reject=2.
REQ-038 Overflow: ev_ready=0, 18 back-to-back events, DEPTH=16 -> fifo_count=16, cnt_ovf=2, ovf_flag=1; release ready -> first 16 events in order.
REQ-039 Full plus simultaneous pop: full, ready=1, and one new event on the same edge -> event accepted, fifo_count stays 16, cnt_ovf unchanged.
REQ-040 Backpressure: random ev_ready over 1000 random events -> output stream equals accepted input stream; ev_data stable while stalled.
REQ-041 Reset mid-run: assert reset asynchronously (between edges) with 5 events stored -> ev_valid=0, fifo_count=0, counters=0 immediately; no stale output after release.
